// File: rtl/led_fade_driver.sv
// led_fade_driver
//  Sits right after the system PIO LED export. Each on/off request bit is
//  turned into a PWM-driven LED whose brightness ramps linearly towards
//  fully on or fully off, one level per step, instead of snapping.
//
//  Optional build macro: LED_FADE_GAMMA_EN
//    defined     -> duty = (level*level) >> PWM_BITS (square-law brightness)
//    not defined -> duty = level (linear brightness)
//  A level of MAX is always driven fully on in both builds.

module led_fade_driver #(
    parameter int N_LEDS   = 8,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 196,
    parameter int STEP_DIV = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [N_LEDS-1:0] leds_in,
    input  logic              enable,
    output logic [N_LEDS-1:0] leds_out,
    output logic              busy,
    output logic              period_tick
);

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);

    logic [N_LEDS-1:0]   req_q;
    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic [PWM_BITS-1:0] level [N_LEDS];
    logic [PWM_BITS-1:0] duty  [N_LEDS];

    logic                pwm_tick;
    logic                period_wrap;
    logic                step_pulse;
    logic [N_LEDS-1:0]   led_on;
    logic [N_LEDS-1:0]   at_target;

    // Capture the LED requests once; every decision below uses this copy.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            req_q <= '0;
        end else begin
            req_q <= leds_in;
        end
    end

    // Timebase strobes: PWM count tick, period wrap and brightness step.
    always_comb begin
        pwm_tick    = enable && (pre_cnt == PRE_LAST);
        period_wrap = pwm_tick && (pwm_cnt == MAX_LEVEL);
        step_pulse  = period_wrap && (step_cnt == STEP_LAST);
    end

    // Prescaler, PWM counter and step divider; all parked at zero while disabled.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            step_cnt    <= '0;
            period_tick <= 1'b0;
        end else if (!enable) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            step_cnt    <= '0;
            period_tick <= 1'b0;
        end else begin
            pre_cnt     <= pwm_tick ? '0 : pre_cnt + PRE_W'(1);
            period_tick <= period_wrap;
            if (pwm_tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            if (period_wrap) begin
                step_cnt <= step_pulse ? '0 : step_cnt + STEP_W'(1);
            end
        end
    end

    // Move each channel level one step towards its target, saturating at 0 and MAX.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < N_LEDS; i++) begin
                level[i] <= '0;
            end
        end else if (step_pulse) begin
            for (int i = 0; i < N_LEDS; i++) begin
                if (req_q[i] && (level[i] != MAX_LEVEL)) begin
                    level[i] <= level[i] + PWM_BITS'(1);
                end else if (!req_q[i] && (level[i] != '0)) begin
                    level[i] <= level[i] - PWM_BITS'(1);
                end
            end
        end
    end

    // Map level to duty, compare against the PWM counter and flag settled channels.
    always_comb begin
        led_on    = '0;
        at_target = '0;
        for (int i = 0; i < N_LEDS; i++) begin
`ifdef LED_FADE_GAMMA_EN
            duty[i] = PWM_BITS'(({{PWM_BITS{1'b0}}, level[i]} *
                                 {{PWM_BITS{1'b0}}, level[i]}) >> PWM_BITS);
`else
            duty[i] = level[i];
`endif
            led_on[i]    = (level[i] == MAX_LEVEL) || (duty[i] > pwm_cnt);
            at_target[i] = req_q[i] ? (level[i] == MAX_LEVEL) : (level[i] == '0);
        end
    end

    // Registered LED drive (blanked when disabled) and fade-in-progress flag.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            leds_out <= '0;
            busy     <= 1'b0;
        end else begin
            leds_out <= enable ? led_on : '0;
            busy     <= |(~at_target);
        end
    end

endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver
//  Directed bench for led_fade_driver with a small, fast configuration
//  (PRESCALE=2, PWM_BITS=4, STEP_DIV=1): one PWM period is 32 clocks and a
//  brightness level can be read back as the number of high cycles of
//  leds_out[0] over a period window. Honours LED_FADE_GAMMA_EN for the
//  expected duty values.

module tb_led_fade_driver;

    localparam int N_LEDS   = 8;
    localparam int PWM_BITS = 4;
    localparam int PRESCALE = 2;
    localparam int STEP_DIV = 1;
    localparam int PERIOD   = 32;

    logic              clk_clk;
    logic              reset_reset_n;
    logic [N_LEDS-1:0] leds_in;
    logic              enable;
    logic [N_LEDS-1:0] leds_out;
    logic              busy;
    logic              period_tick;

    int n_checks;
    int n_fails;

    led_fade_driver #(
        .N_LEDS   (N_LEDS),
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .leds_in       (leds_in),
        .enable        (enable),
        .leds_out      (leds_out),
        .busy          (busy),
        .period_tick   (period_tick)
    );

    // Free-running 10-unit clock.
    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    // Expected high cycles of one LED over a 32-clock period at a given level.
    function automatic int exp_high(input int lvl);
        int d;
        if (lvl == 15) begin
            return PERIOD;
        end
`ifdef LED_FADE_GAMMA_EN
        d = (lvl * lvl) >> PWM_BITS;
`else
        d = lvl;
`endif
        return 2 * d;
    endfunction

    task automatic apply_stimulus(input logic rst_n, input logic en, input logic [N_LEDS-1:0] leds);
        reset_reset_n = rst_n;
        enable        = en;
        leds_in       = leds;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_clk);
        #1;
    endtask

    // Observe one PWM period starting right after a period boundary.
    task automatic measure_window(input string tag, input int lvl, input logic exp_busy);
        int   high;
        int   other;
        int   early;
        logic busy2;
        logic tick_end;
        high     = 0;
        other    = 0;
        early    = 0;
        busy2    = 1'bx;
        tick_end = 1'bx;
        for (int j = 1; j <= PERIOD; j++) begin
            next_cycle();
            high += int'(leds_out[0]);
            if (leds_out[N_LEDS-1:1] != '0) other++;
            if (j < PERIOD && period_tick) early++;
            if (j == 2) busy2 = busy;
            if (j == PERIOD) tick_end = period_tick;
        end
        check_output($sformatf("%s_duty", tag), high, exp_high(lvl));
        check_output($sformatf("%s_others", tag), other, 0);
        check_output($sformatf("%s_period", tag), (early == 0 && tick_end === 1'b1) ? 1 : 0, 1);
        check_output($sformatf("%s_busy", tag), 32'(busy2), 32'(exp_busy));
    endtask

    // Directed sequence covering reset, fades, reversal, enable gating and async reset.
    initial begin
        int quiet;
        n_checks = 0;
        n_fails  = 0;

        apply_stimulus(1'b0, 1'b0, 8'h00);
        repeat (3) next_cycle();
        check_output("rst_leds_out", 32'(leds_out), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_period_tick", 32'(period_tick), 0);

        $display("[TB] idle periods after reset release");
        apply_stimulus(1'b1, 1'b1, 8'h00);
        measure_window("t1_w0", 0, 1'b0);
        measure_window("t1_w1", 0, 1'b0);

        $display("[TB] fade up on LED 0");
        apply_stimulus(1'b1, 1'b1, 8'h01);
        for (int n = 1; n <= 16; n++) begin
            measure_window($sformatf("t2_w%0d", n), n - 1, (n - 1) != 15);
        end

        $display("[TB] fade down on LED 0");
        apply_stimulus(1'b1, 1'b1, 8'h00);
        for (int k = 0; k <= 15; k++) begin
            measure_window($sformatf("t3_w%0d", k), 15 - k, (15 - k) != 0);
        end
        measure_window("t3_rest", 0, 1'b0);

        $display("[TB] direction reversal mid-fade");
        apply_stimulus(1'b1, 1'b1, 8'h01);
        for (int k = 0; k <= 5; k++) begin
            measure_window($sformatf("t4_up%0d", k), k, 1'b1);
        end
        apply_stimulus(1'b1, 1'b1, 8'h00);
        measure_window("t4_drop6", 6, 1'b1);
        measure_window("t4_drop5", 5, 1'b1);
        apply_stimulus(1'b1, 1'b1, 8'h01);
        measure_window("t4_raise4", 4, 1'b1);
        measure_window("t4_raise5", 5, 1'b1);
        measure_window("t4_raise6", 6, 1'b1);

        $display("[TB] enable gating at level 7");
        repeat (5) next_cycle();
        check_output("t5_pre_on", 32'(leds_out), 32'h01);
        apply_stimulus(1'b1, 1'b0, 8'h01);
        next_cycle();
        check_output("t5_blank", 32'(leds_out), 0);
        check_output("t5_tick_off", 32'(period_tick), 0);
        quiet = 0;
        for (int j = 0; j < 200; j++) begin
            next_cycle();
            if (leds_out != '0 || period_tick) quiet++;
        end
        check_output("t5_quiet", quiet, 0);
        check_output("t5_busy_held", 32'(busy), 1);
        apply_stimulus(1'b1, 1'b1, 8'h01);
        measure_window("t5_resume7", 7, 1'b1);
        measure_window("t5_resume8", 8, 1'b1);

        $display("[TB] async reset mid-fade at level 9");
        repeat (10) next_cycle();
        check_output("t6_pre_on", 32'(leds_out), 32'h01);
        check_output("t6_pre_busy", 32'(busy), 1);
        #2;
        apply_stimulus(1'b0, 1'b1, 8'h01);
        #1;
        check_output("t6_async_leds", 32'(leds_out), 0);
        check_output("t6_async_busy", 32'(busy), 0);
        check_output("t6_async_tick", 32'(period_tick), 0);
        repeat (3) next_cycle();
        apply_stimulus(1'b1, 1'b1, 8'h01);
        measure_window("t6_restart0", 0, 1'b1);
        measure_window("t6_restart1", 1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
